// File: rtl/serial_tx_ctrl.sv
// Parallel-in/serial-out transmit sequencer: valid/ready word intake, LSB-first shift-out at DIV clocks per bit.
// Optional even-parity bit after the data word when SER_PARITY_EN is defined.
module serial_tx_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       valid,
  output logic                       ready,
  input  logic                       abort,
  output logic                       outb,
  output logic                       frame,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
`ifdef SER_PARITY_EN
    S_PARITY = 2'd2,
`endif
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [DIV_W-1:0]   r_div_cnt, w_div_cnt_nxt;
  logic               r_outb, w_outb_nxt;
  logic               r_frame, w_frame_nxt;
  logic               r_done, w_done_nxt;
`ifdef SER_PARITY_EN
  logic               r_par, w_par_nxt;
`endif

  logic w_accept, w_tick, w_last;

  assign ready    = (r_state == S_IDLE) & ~abort;
  assign w_accept = ready & valid;
  assign w_tick   = (r_div_cnt == DIV_W'(DIV - 1));
  assign w_last   = (r_bit_cnt == CNT_W'(WIDTH - 1));

  assign outb    = r_outb;
  assign frame   = r_frame;
  assign done    = r_done;
  assign bit_cnt = r_bit_cnt;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_outb    <= 1'b1;
      r_frame   <= 1'b0;
      r_done    <= 1'b0;
`ifdef SER_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_outb    <= w_outb_nxt;
      r_frame   <= w_frame_nxt;
      r_done    <= w_done_nxt;
`ifdef SER_PARITY_EN
      r_par     <= w_par_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick && w_last) begin
`ifdef SER_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      S_PARITY: if (abort || w_tick) w_state_nxt = S_IDLE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values; defaults are the idle levels so abort needs no branch of its own
  always_comb begin
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = '0;
    w_div_cnt_nxt = '0;
    w_outb_nxt    = 1'b1;
    w_frame_nxt   = 1'b0;
    w_done_nxt    = 1'b0;
`ifdef SER_PARITY_EN
    w_par_nxt     = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shreg_nxt = data_in;
          w_outb_nxt  = data_in[0];
          w_frame_nxt = 1'b1;
`ifdef SER_PARITY_EN
          w_par_nxt   = ^data_in;
`endif
        end
      end
      S_SHIFT: begin
        if (!abort) begin
          w_frame_nxt   = 1'b1;
          w_outb_nxt    = r_shreg[0];
          w_bit_cnt_nxt = r_bit_cnt;
          w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
          if (w_tick) begin
            w_div_cnt_nxt = '0;
            w_shreg_nxt   = r_shreg >> 1;
            if (w_last) begin
`ifdef SER_PARITY_EN
              w_bit_cnt_nxt = CNT_W'(WIDTH);
              w_outb_nxt    = r_par;
`else
              w_bit_cnt_nxt = '0;
              w_outb_nxt    = 1'b1;
              w_frame_nxt   = 1'b0;
              w_done_nxt    = 1'b1;
`endif
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
              w_outb_nxt    = r_shreg[1];
            end
          end
        end
      end
`ifdef SER_PARITY_EN
      S_PARITY: begin
        if (!abort) begin
          if (w_tick) begin
            w_done_nxt = 1'b1;
          end else begin
            w_frame_nxt   = 1'b1;
            w_outb_nxt    = r_par;
            w_bit_cnt_nxt = r_bit_cnt;
            w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
          end
        end
      end
`endif
      default: ;
    endcase
  end

endmodule
